rvb_clmul_pcpi_ctrl: RTL and testbench

//  PCPI front-end for the combinational carry-less multiply unit (rvb_clmul).
//  - Decodes CLMUL/CLMULH from the core's PCPI bus and latches operands.
//  - Drives the unit's valid/op/operand inputs and waits a programmable settle time.
//  - Registers the result and returns it with a single-cycle ready/write pulse.

---
 rtl/rvb_clmul_pcpi_ctrl.sv | 145 ++++++++++++++
 tb/tb_rvb_clmul_pcpi_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_clmul_pcpi_ctrl.sv
// PCPI front-end for the combinational carry-less multiplier: decode, operand latch, settle wait, result return.
// Define RVB_CLMULR_EN to also accept CLMULR (funct3 3'b010) and expose op_clmulr.
module rvb_clmul_pcpi_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        clmul_valid,
  output logic        op_clmul,
  output logic        op_clmulh,
`ifdef RVB_CLMULR_EN
  output logic        op_clmulr,
`endif
  output logic [31:0] clmul_rs1,
  output logic [31:0] clmul_rs2,
  input  logic [31:0] clmul_rd
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP, HOLD} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rd_q, rd_d;
  logic        op_clmul_q, op_clmul_d;
  logic        op_clmulh_q, op_clmulh_d;
  logic        is_base, dec_clmul, dec_clmulh, dec_clmulr, match;
  logic        unused_insn_bits;

  assign is_base    = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000101);
  assign dec_clmul  = is_base && (pcpi_insn[14:12] == 3'b001);
  assign dec_clmulh = is_base && (pcpi_insn[14:12] == 3'b011);
`ifdef RVB_CLMULR_EN
  assign dec_clmulr = is_base && (pcpi_insn[14:12] == 3'b010);
`else
  assign dec_clmulr = 1'b0;
`endif
  assign match = dec_clmul | dec_clmulh | dec_clmulr;

  // Register fields are irrelevant here; the core owns rd/rs addressing.
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

`ifdef RVB_CLMULR_EN
  logic op_clmulr_q, op_clmulr_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    op_clmul_d  = op_clmul_q;
    op_clmulh_d = op_clmulh_q;
`ifdef RVB_CLMULR_EN
    op_clmulr_d = op_clmulr_q;
`endif
    clmul_valid = 1'b0;
    pcpi_wait   = 1'b0;
    pcpi_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pcpi_valid && match) begin
          rs1_d       = pcpi_rs1;
          rs2_d       = pcpi_rs2;
          op_clmul_d  = dec_clmul;
          op_clmulh_d = dec_clmulh;
`ifdef RVB_CLMULR_EN
          op_clmulr_d = dec_clmulr;
`endif
          cnt_d       = 4'd0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        clmul_valid = 1'b1;
        pcpi_wait   = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        // Abort wins over capture so a withdrawn instruction never writes back.
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          rd_d    = clmul_rd;
          state_d = RESP;
        end
      end
      RESP: begin
        pcpi_ready = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rs1_q       <= 32'd0;
      rs2_q       <= 32'd0;
      rd_q        <= 32'd0;
      op_clmul_q  <= 1'b0;
      op_clmulh_q <= 1'b0;
`ifdef RVB_CLMULR_EN
      op_clmulr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      op_clmul_q  <= op_clmul_d;
      op_clmulh_q <= op_clmulh_d;
`ifdef RVB_CLMULR_EN
      op_clmulr_q <= op_clmulr_d;
`endif
    end
  end

  assign pcpi_wr   = pcpi_ready;
  assign pcpi_rd   = rd_q;
  assign clmul_rs1 = rs1_q;
  assign clmul_rs2 = rs2_q;
  assign op_clmul  = op_clmul_q;
  assign op_clmulh = op_clmulh_q;
`ifdef RVB_CLMULR_EN
  assign op_clmulr = op_clmulr_q && (state_q == EXEC);
`endif

endmodule

// File: tb/tb_rvb_clmul_pcpi_ctrl.sv
// Scoreboard bench for rvb_clmul_pcpi_ctrl with a behavioural clmul unit that only settles after LATENCY cycles.
module tb_rvb_clmul_pcpi_ctrl;

  localparam int LAT = 2;
`ifdef RVB_CLMULR_EN
  localparam bit HAS_R = 1'b1;
`else
  localparam bit HAS_R = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        clmul_valid, op_clmul, op_clmulh;
  logic [31:0] clmul_rs1, clmul_rs2, clmul_rd;
`ifdef RVB_CLMULR_EN
  logic        op_clmulr;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int settle = 0;

  logic [31:0] expRd[$];
  int          expCyc[$];

  rvb_clmul_pcpi_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .clmul_valid(clmul_valid), .op_clmul(op_clmul), .op_clmulh(op_clmulh),
`ifdef RVB_CLMULR_EN
    .op_clmulr(op_clmulr),
`endif
    .clmul_rs1(clmul_rs1), .clmul_rs2(clmul_rs2), .clmul_rd(clmul_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Full 64-bit carry-less product as a sum of shifted partial products.
  function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 32; i++)
      if (b[i]) r = r ^ ({32'd0, a} << i);
    return r;
  endfunction

  function automatic bit refMatch(input logic [31:0] insn);
    if (insn[6:0] != 7'b0110011 || insn[31:25] != 7'b0000101) return 1'b0;
    case (insn[14:12])
      3'b001, 3'b011: return 1'b1;
      3'b010:         return HAS_R;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refResult(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = clmul64(a, b);
    case (insn[14:12])
      3'b011:  return p[63:32];
      3'b010:  return p[62:31];
      default: return p[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mkInsn(input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {7'b0000101, r[24:15], f3, r[11:7], 7'b0110011};
  endfunction

  // Behavioural clmul unit: output is garbage until operands have been valid for LAT-1 full cycles.
  always @(posedge clk) settle <= clmul_valid ? settle + 1 : 0;

  always_comb begin
    logic [63:0] p;
    logic        selR;
    p = clmul64(clmul_rs1, clmul_rs2);
`ifdef RVB_CLMULR_EN
    selR = op_clmulr;
`else
    selR = 1'b0;
`endif
    clmul_rd = 32'hDEADBEEF;
    if (clmul_valid && settle >= LAT - 1) begin
      if (op_clmulh)     clmul_rd = p[63:32];
      else if (selR)     clmul_rd = p[62:31];
      else if (op_clmul) clmul_rd = p[31:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must correspond to the oldest outstanding expectation.
  always @(negedge clk) begin
    if (pcpi_ready || pcpi_wr) begin
      checkOutput("wr equals ready", {31'd0, pcpi_wr}, {31'd0, pcpi_ready});
      if (expRd.size() == 0) begin
        checkOutput("unexpected ready", {31'd0, pcpi_ready}, 32'd0);
      end else begin
        logic [31:0] e;
        int          c;
        e = expRd.pop_front();
        c = expCyc.pop_front();
        checkOutput("pcpi_rd", pcpi_rd, e);
        checkOutput("ready cycle", 32'(cyc), 32'(c));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " pcpi_rd"}, pcpi_rd, 32'd0);
    checkOutput({tag, " ctrl"}, {26'd0, pcpi_wr, pcpi_wait, pcpi_ready, clmul_valid, op_clmul, op_clmulh}, 32'd0);
    checkOutput({tag, " clmul_rs1"}, clmul_rs1, 32'd0);
    checkOutput({tag, " clmul_rs2"}, clmul_rs2, 32'd0);
`ifdef RVB_CLMULR_EN
    checkOutput({tag, " op_clmulr"}, {31'd0, op_clmulr}, 32'd0);
`endif
  endtask

  // Present one instruction; dropAt>0 withdraws valid in that EXEC cycle, holdAfter keeps valid past ready.
  task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                               input int dropAt, input int holdAfter);
    bit match;
    int span;
    logic expW;
    match = refMatch(insn);
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    if (match && dropAt <= 0) begin
      expRd.push_back(refResult(insn, a, b));
      expCyc.push_back(cyc + LAT + 1);
    end
    span = match ? LAT + 1 + holdAfter : 20;
    for (int k = 1; k <= span; k++) begin
      @(posedge clk); #1;
      pcpi_rs1 = $urandom;
      pcpi_rs2 = $urandom;
      if (k == dropAt) pcpi_valid = 1'b0;
      @(negedge clk);
      expW = match && k <= LAT && (dropAt <= 0 || k <= dropAt);
      checkOutput("pcpi_wait", {31'd0, pcpi_wait}, {31'd0, expW});
      checkOutput("clmul_valid", {31'd0, clmul_valid}, {31'd0, expW});
      if (expW) begin
        checkOutput("op select", {30'd0, op_clmul, op_clmulh},
                    {30'd0, insn[14:12] == 3'b001, insn[14:12] == 3'b011});
`ifdef RVB_CLMULR_EN
        checkOutput("op_clmulr", {31'd0, op_clmulr}, {31'd0, insn[14:12] == 3'b010});
`endif
        checkOutput("clmul_rs1 latched", clmul_rs1, a);
        checkOutput("clmul_rs2 latched", clmul_rs2, b);
      end
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  task automatic resetMidExec();
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mkInsn(3'b001);
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("mid-exec reset");
    reset      = 1'b0;
    pcpi_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] insn;
    int          sel;
    int          pick;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(mkInsn(3'b001), 32'h00000003, 32'h00000003, 0, 0);
    applyStimulus(mkInsn(3'b011), 32'h80000000, 32'h80000000, 0, 0);
    applyStimulus(mkInsn(3'b010), 32'h80000000, 32'h80000000, 0, 0);
    applyStimulus(mkInsn(3'b001), 32'h12345678, 32'h9abcdef0, 1, 0);
    applyStimulus(mkInsn(3'b001), 32'hffffffff, 32'hffffffff, 0, 0);
    resetMidExec();
    applyStimulus(mkInsn(3'b011), 32'hcafef00d, 32'h0badbeef, 0, 3);
    applyStimulus(mkInsn(3'b001), 32'h00000007, 32'h00000005, 0, 0);

    $display("[TB] random operations");
    repeat (40) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      insn = mkInsn(3'b001);
      else if (sel < 6) insn = mkInsn(3'b011);
      else if (sel < 7) insn = mkInsn(3'b010);
      else if (sel < 8) insn = mkInsn(3'($urandom));
      else begin
        insn = mkInsn(3'b001);
        pick = $urandom_range(0, 13);
        insn = insn ^ (32'd1 << (pick < 7 ? pick : pick + 18));
      end
      applyStimulus(insn, $urandom, $urandom,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT) : 0,
                    $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 32'(expRd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
